// File: rtl/hex_display_scanner_pkg.sv
// Shared defaults and helpers for the multiplexed 7-segment scan controller.
package hex_display_scanner_pkg;

  localparam int NUM_DIGITS_DEF   = 4;
  localparam int CLK_DIV_DEF      = 50000;
  localparam int BLINK_FRAMES_DEF = 64;
  localparam int NIBBLE_W         = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Counter width that stays at least one bit for degenerate counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_display_scanner_tick_divider.sv
// Free-running divider: one-cycle tick every CLK_DIV clocks.
module tick_divider #(
  parameter int  CLK_DIV = 50000,
  localparam int CW      = $clog2(CLK_DIV)
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Scan controller: frame-synchronous commit of the CPU value, digit select,
// leading-zero blanking and whole-display blinking for a multiplexed 7-seg.
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter int  NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int  CLK_DIV      = CLK_DIV_DEF,
  parameter int  BLINK_FRAMES = BLINK_FRAMES_DEF,
  localparam int IDX_W        = idx_width(NUM_DIGITS),
  localparam int FRM_W        = idx_width(BLINK_FRAMES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output nibble_t                 nibble,
  output logic [NUM_DIGITS-1:0]   digit_an_n,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    upd_pending
);

  logic                    tick;
  logic [4*NUM_DIGITS-1:0] disp_reg;
  logic [4*NUM_DIGITS-1:0] pend_reg;
  logic [4*NUM_DIGITS-1:0] src;
  logic [IDX_W-1:0]        idx_nxt;
  logic                    frame_start;
  logic                    commit;
  logic                    frame_wrap;
  logic                    phase_nxt;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [FRM_W-1:0]        frame_cnt;
  logic                    blink_phase;

  tick_divider #(.CLK_DIV(CLK_DIV)) u_tick_divider (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_comb begin
    idx_nxt     = (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    frame_start = tick & (idx_nxt == '0);
    commit      = frame_start & upd_pending;
    src         = commit ? pend_reg : disp_reg;
    frame_wrap  = (frame_cnt == FRM_W'(BLINK_FRAMES - 1));
    // Use the post-toggle phase so a whole frame blinks together, digit 0 included.
    phase_nxt   = (frame_start & frame_wrap) ? ~blink_phase : blink_phase;
  end

  // A digit is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (src[4*i +: 4] == 4'h0);
      if (i != 0) blank_mask[i] = blank_lz & zero_run;
    end
  end

  always_comb begin
    an_nxt = '1;
    if (!blank_mask[idx_nxt] && !(blink_en && phase_nxt)) an_nxt[idx_nxt] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nibble      <= '0;
      digit_an_n  <= '1;
      digit_idx   <= IDX_W'(NUM_DIGITS - 1);
      upd_pending <= 1'b0;
      disp_reg    <= '0;
      pend_reg    <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (wr_en) pend_reg <= wr_data;
      // A write on the commit tick re-arms pending for the next frame.
      if (wr_en) begin
        upd_pending <= 1'b1;
      end else if (commit) begin
        upd_pending <= 1'b0;
      end
      if (tick) begin
        if (commit) disp_reg <= pend_reg;
        digit_idx  <= idx_nxt;
        nibble     <= src[{idx_nxt, 2'b00} +: 4];
        digit_an_n <= an_nxt;
        if (frame_start) begin
          frame_cnt   <= frame_wrap ? '0 : frame_cnt + FRM_W'(1);
          blink_phase <= phase_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: table of display values plus scoreboarded scan sequences.
module tb_hex_display_scanner;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        blank_lz;
  logic        blink_en;
  logic [3:0]  nibble;
  logic [3:0]  digit_an_n;
  logic [1:0]  digit_idx;
  logic        upd_pending;

  int tests  = 0;
  int failed = 0;
  int edges  = 0;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] nib;
    logic [3:0] an;
    logic       pend;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    logic        lz;
    logic [15:0] ans;   // {an3, an2, an1, an0}
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  hex_display_scanner #(.NUM_DIGITS(4), .CLK_DIV(CLK_DIV), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .nibble     (nibble),
    .digit_an_n (digit_an_n),
    .digit_idx  (digit_idx),
    .upd_pending(upd_pending)
  );

  always #5 clk = ~clk;

  // Edges since the reset edge; the divider ticks on every CLK_DIV-th one.
  always @(posedge clk) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic reset_dut(input logic lz, input logic blink);
    reset    = 1'b1;
    wr_en    = 1'b0;
    blank_lz = lz;
    blink_en = blink;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write(input logic [15:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string name);
    tests++;
    if ({nibble, digit_an_n, digit_idx, upd_pending} !== {4'h0, 4'hF, 2'd3, 1'b0}) begin
      failed++;
      $display("FAIL %s: got nib=%h an=%h idx=%0d pend=%b, expected nib=0 an=f idx=3 pend=0",
               name, nibble, digit_an_n, digit_idx, upd_pending);
    end
  endtask

  task automatic check_slot(input string name, input exp_t e);
    tests++;
    if ({digit_idx, nibble, digit_an_n, upd_pending} !== e) begin
      failed++;
      $display("FAIL %s: got idx=%0d nib=%h an=%h pend=%b, expected idx=%0d nib=%h an=%h pend=%b",
               name, digit_idx, nibble, digit_an_n, upd_pending, e.idx, e.nib, e.an, e.pend);
    end
  endtask

  task automatic wait_tick(input string name);
    bit found = 1'b0;
    for (int k = 0; k < 2*CLK_DIV; k++) begin
      @(negedge clk);
      if (edges % CLK_DIV == 0 && edges != 0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      tests++;
      failed++;
      $display("FAIL %s: no slot tick within %0d cycles", name, 2*CLK_DIV);
    end
  endtask

  task automatic push(input int idx, input logic [3:0] nib, input logic [3:0] an, input logic pend);
    exp_t e;
    e.idx  = 2'(idx);
    e.nib  = nib;
    e.an   = an;
    e.pend = pend;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    exp_t e;
    while (sb.size() > 0) begin
      wait_tick(name);
      e = sb.pop_front();
      check_slot(name, e);
    end
  endtask

  initial begin
    logic [15:0] val;
    logic [3:0]  an;
    bit          blank;

    vecs[0] = '{16'h1A2F, 1'b0, 16'h7BDE};
    vecs[1] = '{16'h0030, 1'b1, 16'hFFDE};
    vecs[2] = '{16'h0000, 1'b1, 16'hFFFE};
    vecs[3] = '{16'h0000, 1'b0, 16'h7BDE};
    vecs[4] = '{16'h1000, 1'b1, 16'h7BDE};
    vecs[5] = '{16'h0F00, 1'b1, 16'hFBDE};
    vecs[6] = '{16'hABCD, 1'b1, 16'h7BDE};

    reset = 1'b1; wr_en = 1'b0; wr_data = '0; blank_lz = 1'b0; blink_en = 1'b0;
    repeat (2) @(negedge clk);

    // Table: each value commits at the first frame start after the write.
    for (int v = 0; v < 7; v++) begin
      reset_dut(vecs[v].lz, 1'b0);
      check_reset_state("vec_reset");
      write(vecs[v].data);
      check_bit("vec_pend_set", upd_pending, 1'b1);
      val = vecs[v].data;
      for (int d = 0; d < 4; d++) push(d, val[4*d +: 4], vecs[v].ans[4*d +: 4], 1'b0);
      drain("vec_slot");
    end

    // Two writes mid-frame: display holds until the next frame, last write wins.
    reset_dut(1'b0, 1'b0);
    write(16'h1A2F);
    wait_tick("midwr_first");
    check_slot("midwr_first", '{2'd0, 4'hF, 4'hE, 1'b0});
    check_bit("midwr_pend_idle", upd_pending, 1'b0);
    write(16'h1111);
    check_bit("midwr_pend_after_wr", upd_pending, 1'b1);
    @(negedge clk);
    write(16'h2222);
    check_bit("midwr_pend_after_wr2", upd_pending, 1'b1);
    push(1, 4'h2, 4'hD, 1'b1); push(2, 4'hA, 4'hB, 1'b1); push(3, 4'h1, 4'h7, 1'b1);
    for (int d = 0; d < 4; d++) push(d, 4'h2, ~(4'b1 << d), 1'b0);
    drain("midwr_slot");

    // Write landing on the commit tick stays pending for one more frame.
    reset_dut(1'b0, 1'b0);
    write(16'h4444);
    repeat (2) @(negedge clk);
    write(16'h5555);
    check_slot("cwr_first", '{2'd0, 4'h4, 4'hE, 1'b1});
    push(1, 4'h4, 4'hD, 1'b1); push(2, 4'h4, 4'hB, 1'b1); push(3, 4'h4, 4'h7, 1'b1);
    for (int d = 0; d < 4; d++) push(d, 4'h5, ~(4'b1 << d), 1'b0);
    drain("cwr_slot");

    // Blink with two frames per half-period; frames 2,3 and 6 are dark.
    reset_dut(1'b0, 1'b1);
    write(16'h1A2F);
    val = 16'h1A2F;
    for (int f = 1; f <= 5; f++) begin
      blank = (f == 2 || f == 3);
      for (int d = 0; d < 4; d++) begin
        an = blank ? 4'hF : ~(4'b1 << d);
        push(d, val[4*d +: 4], an, 1'b0);
      end
    end
    push(0, 4'hF, 4'hF, 1'b0);
    drain("blink_slot");
    blink_en = 1'b0;
    push(1, 4'h2, 4'hD, 1'b0); push(2, 4'hA, 4'hB, 1'b0);
    drain("blink_off_slot");

    // Reset mid-frame with a write pending discards the write.
    reset_dut(1'b0, 1'b0);
    write(16'h1A2F);
    wait_tick("rst_pre");
    check_slot("rst_pre", '{2'd0, 4'hF, 4'hE, 1'b0});
    write(16'h7777);
    check_bit("rst_pend_before", upd_pending, 1'b1);
    reset_dut(1'b0, 1'b0);
    check_reset_state("rst_mid");
    push(0, 4'h0, 4'hE, 1'b0); push(1, 4'h0, 4'hD, 1'b0);
    drain("rst_after_slot");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
